uart_rx: RTL and testbench

- Asynchronous serial receiver, 8N1-style framing: 1 start bit, NrOfDataBits data bits (LSB first), 1 stop bit, no parity.
- Receive-side counterpart of the existing UART transmit path, with matching parameterisation and bit timing, so a TX/RX pair built from the same parameters interoperates.
- Takes the raw pin `rx`, samples each bit at its centre, and presents each received word with a one-cycle `done` strobe. Framing errors are reported separately.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and bit-timing math used by both
// the receive and transmit paths so a matched pair derives identical timing.
package uart_pkg;

    typedef enum logic [2:0] {
        Idle     = 3'd0,
        StartBit = 3'd1,
        DataBits = 3'd2,
        StopBit  = 3'd3,
        WaitIdle = 3'd4
    } uart_state_e;

    // Clock cycles per bit period (truncated). Callers must keep this >= 4.
    function automatic int bit_ticks(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // Clock cycles to the centre of a bit, measured from its leading edge.
    function automatic int half_ticks(input int clock_frequency, input int baud_rate);
        return bit_ticks(clock_frequency, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: d -> meta -> q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 1 start / NrOfDataBits data (LSB first) / 1 stop, no parity.
// Start bit is validated at its centre; every later bit is sampled one full
// bit period after the previous sample. The stop sample returns to Idle
// half a bit early so back-to-back frames have no dead time.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600,
    parameter int NrOfDataBits   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    output logic [NrOfDataBits-1:0] dataBits,
    output logic                    done,
    output logic                    frameError,
    output logic                    busy
);

    localparam int BitTicks  = bit_ticks(ClockFrequency, BaudRate);
    localparam int HalfTicks = half_ticks(ClockFrequency, BaudRate);
    localparam int TickW     = $clog2(BitTicks);
    localparam int IdxW      = (NrOfDataBits > 1) ? $clog2(NrOfDataBits) : 1;

    localparam logic [TickW-1:0] TickLast = TickW'(BitTicks - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(HalfTicks - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NrOfDataBits - 1);

    logic                    rx_s;
    uart_state_e             state_q, state_next;
    logic [TickW-1:0]        tick_q, tick_next;
    logic [IdxW-1:0]         idx_q, idx_next;
    logic [NrOfDataBits-1:0] shift_q, shift_next;
    logic [NrOfDataBits-1:0] data_next;
    logic                    done_next, ferr_next;

    uart_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state_q != Idle);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= Idle;
        else        state_q <= state_next;
    end

    // Counters, shift register and registered output strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            dataBits   <= '0;
            done       <= 1'b0;
            frameError <= 1'b0;
        end else begin
            tick_q     <= tick_next;
            idx_q      <= idx_next;
            shift_q    <= shift_next;
            dataBits   <= data_next;
            done       <= done_next;
            frameError <= ferr_next;
        end
    end

    // Next-state and datapath decode; strobes default low so they last one cycle.
    always_comb begin
        state_next = state_q;
        tick_next  = tick_q;
        idx_next   = idx_q;
        shift_next = shift_q;
        data_next  = dataBits;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state_q)
            Idle: begin
                if (!rx_s) begin
                    state_next = StartBit;
                    tick_next  = '0;
                end
            end
            StartBit: begin
                if (tick_q == TickHalf) begin
                    if (rx_s) begin
                        // Low pulse did not survive to mid-bit: treat as glitch.
                        state_next = Idle;
                    end else begin
                        state_next = DataBits;
                        tick_next  = '0;
                        idx_next   = '0;
                    end
                end else begin
                    tick_next = tick_q + 1'b1;
                end
            end
            DataBits: begin
                if (tick_q == TickLast) begin
                    tick_next = '0;
                    // Shift in from the MSB side so the first bit lands in bit 0.
                    shift_next = shift_q >> 1;
                    shift_next[NrOfDataBits-1] = rx_s;
                    if (idx_q == IdxLast) state_next = StopBit;
                    else                  idx_next   = idx_q + 1'b1;
                end else begin
                    tick_next = tick_q + 1'b1;
                end
            end
            StopBit: begin
                if (tick_q == TickLast) begin
                    tick_next = '0;
                    if (rx_s) begin
                        data_next  = shift_q;
                        done_next  = 1'b1;
                        state_next = Idle;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WaitIdle;
                    end
                end else begin
                    tick_next = tick_q + 1'b1;
                end
            end
            WaitIdle: begin
                // Hold off until the line is released so a break gives one error.
                if (rx_s) state_next = Idle;
            end
            default: state_next = Idle;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level reference model (2-cycle line delay,
// centre-sample arithmetic on a line history) checked every cycle, plus
// hand-computed literal checks for each directed scenario.
module tb_uart_rx;

    localparam int N = 8;
    localparam int B = 16;   // 1600 Hz / 100 baud
    localparam int H = 8;
    localparam int HistLen = 8192;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         rx    = 1'b1;
    logic [N-1:0] dataBits;
    logic         done, frameError, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_rx #(
        .ClockFrequency (1600),
        .BaudRate       (100),
        .NrOfDataBits   (N)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .dataBits   (dataBits),
        .done       (done),
        .frameError (frameError),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_FRAME, M_WAIT} mmode_e;
    logic         line_hist [HistLen];
    int           k = 0;
    int           j0 = 0;
    logic         d1 = 1'b1, d2 = 1'b1;
    mmode_e       mode = M_IDLE;
    logic [N-1:0] exp_data = '0;
    logic         exp_done = 1'b0, exp_ferr = 1'b0;

    // The receiver sees the line two clocks late; a frame starting at edge j0
    // is judged at j0+H (start), j0+H+(i+1)*B (data i), j0+H+(N+1)*B (stop).
    always @(posedge clock or negedge reset) begin : model_p
        logic         s;
        logic [N-1:0] w;
        if (!reset) begin
            d1 = 1'b1; d2 = 1'b1;
            mode = M_IDLE;
            exp_data = '0; exp_done = 1'b0; exp_ferr = 1'b0;
        end else begin
            s = d2;
            line_hist[k % HistLen] = s;
            d2 = d1;
            d1 = rx;
            exp_done = 1'b0;
            exp_ferr = 1'b0;
            case (mode)
                M_IDLE: if (!s) begin mode = M_FRAME; j0 = k; end
                M_FRAME: begin
                    if (k == j0 + H && s) begin
                        mode = M_IDLE;
                    end else if (k == j0 + H + (N + 1) * B) begin
                        for (int i = 0; i < N; i++)
                            w[i] = line_hist[(j0 + H + (i + 1) * B) % HistLen];
                        if (s) begin exp_data = w; exp_done = 1'b1; mode = M_IDLE; end
                        else   begin exp_ferr = 1'b1; mode = M_WAIT; end
                    end
                end
                M_WAIT: if (s) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
            k++;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        chk("dataBits", 32'(dataBits), 32'(exp_data));
        chk("done", 32'(done), 32'(exp_done));
        chk("frameError", 32'(frameError), 32'(exp_ferr));
        chk("busy", 32'(busy), 32'(mode != M_IDLE));
        chk("done_ferr_excl", 32'(done & frameError), 32'd0);
    end

    // ---------------- event monitor for literal checks ----------------
    int           n_done = 0, n_ferr = 0;
    int           done_q[$];
    logic [N-1:0] word_q[$];
    logic         busy_prev = 1'b0, busy_at_done = 1'b1, busy_before_done = 1'b0;
    int           busy_fall_cyc = 0;

    always @(negedge clock) begin
        if (done) begin
            n_done++;
            done_q.push_back(cyc);
            word_q.push_back(dataBits);
            busy_at_done     = busy;
            busy_before_done = busy_prev;
        end
        if (frameError) n_ferr++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    // ---------------- stimulus ----------------
    int fall_cyc = 0;

    task automatic drive_bit(input logic v, input int period);
        rx = v;
        repeat (period) @(negedge clock);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input int period, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0, period);
        for (int i = 0; i < N; i++) drive_bit(d[i], period);
        drive_bit(stop, period);
    endtask

    initial begin : stim
        int nd, nf, rise_cyc;
        logic [7:0] pat;
        pat = 8'h81;

        // Reset state
        @(negedge clock);
        chk("reset_dataBits", 32'(dataBits), 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        drive_bit(1'b1, 20);

        // 0xA5, single frame
        nd = n_done; nf = n_ferr;
        send_frame(8'hA5, B, 1'b1);
        drive_bit(1'b1, 40);
        chk("a5_done_count", 32'(n_done - nd), 32'd1);
        chk("a5_ferr_count", 32'(n_ferr - nf), 32'd0);
        chk("a5_dataBits", 32'(dataBits), 32'hA5);
        chk("a5_model_word", 32'(exp_data), 32'hA5);
        chk("a5_latency", 32'(done_q[$] - fall_cyc), 32'd155);
        chk("a5_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("a5_busy_before_done", 32'(busy_before_done), 32'd1);

        // 0x3C then 0xFF back-to-back
        nd = n_done;
        send_frame(8'h3C, B, 1'b1);
        send_frame(8'hFF, B, 1'b1);
        drive_bit(1'b1, 40);
        chk("b2b_done_count", 32'(n_done - nd), 32'd2);
        chk("b2b_word0", 32'(word_q[word_q.size()-2]), 32'h3C);
        chk("b2b_word1", 32'(word_q[word_q.size()-1]), 32'hFF);
        chk("b2b_spacing", 32'(done_q[done_q.size()-1] - done_q[done_q.size()-2]), 32'd160);

        // 4-cycle glitch
        nd = n_done; nf = n_ferr;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        chk("glitch_done_count", 32'(n_done - nd), 32'd0);
        chk("glitch_ferr_count", 32'(n_ferr - nf), 32'd0);
        chk("glitch_dataBits", 32'(dataBits), 32'hFF);
        chk("glitch_busy", 32'(busy), 32'd0);

        // 0x55 with bad stop, line held low, then released
        nd = n_done; nf = n_ferr;
        send_frame(8'h55, B, 1'b0);
        drive_bit(1'b0, 100);
        rise_cyc = cyc;
        drive_bit(1'b1, 40);
        chk("ferr_count", 32'(n_ferr - nf), 32'd1);
        chk("ferr_done_count", 32'(n_done - nd), 32'd0);
        chk("ferr_dataBits", 32'(dataBits), 32'hFF);
        chk("ferr_busy_release", 32'(busy_fall_cyc - rise_cyc), 32'd3);

        // Reset during data bit 4, then clean 0x81
        nd = n_done; nf = n_ferr;
        drive_bit(1'b0, B);
        for (int i = 0; i < 4; i++) drive_bit(pat[i], B);
        rx = pat[4];
        repeat (8) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midreset_dataBits", 32'(dataBits), 32'h0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_frameError", 32'(frameError), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        drive_bit(1'b1, 20);
        send_frame(8'h81, B, 1'b1);
        drive_bit(1'b1, 40);
        chk("post_reset_done_count", 32'(n_done - nd), 32'd1);
        chk("post_reset_ferr_count", 32'(n_ferr - nf), 32'd0);
        chk("post_reset_dataBits", 32'(dataBits), 32'h81);

        // Baud tolerance: period 15 and 17
        nd = n_done; nf = n_ferr;
        send_frame(8'hC3, 15, 1'b1);
        drive_bit(1'b1, 40);
        chk("fast_word", 32'(word_q[$]), 32'hC3);
        send_frame(8'hC3, 17, 1'b1);
        drive_bit(1'b1, 40);
        chk("slow_word", 32'(word_q[$]), 32'hC3);
        chk("tol_done_count", 32'(n_done - nd), 32'd2);
        chk("tol_ferr_count", 32'(n_ferr - nf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
